// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and width helpers for the systolic operand feeds
package systolic_pkg;
  localparam int OP_BITS = 8;
  typedef logic signed [OP_BITS-1:0] operand_t;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int rowbits(input int dim);
    return dim > 1 ? $clog2(dim) : 1;
  endfunction
  function automatic int stepbits(input int dim);
    return $clog2(2 * dim - 1);
  endfunction
endpackage

// File: rtl/operand_bank.sv
// operand_bank: DIM x DIM register tile with a row write port and DIM element read ports
module operand_bank import systolic_pkg::*; #(
  parameter int BITS = 8,
  parameter int DIM = 8,
  localparam int RB = rowbits(DIM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [RB-1:0]       wrow,
  input  logic [DIM*BITS-1:0] wdata,
  input  logic [DIM*RB-1:0]   rrow,
  input  logic [DIM*RB-1:0]   rcol,
  output logic [DIM*BITS-1:0] rdata
);
  logic [BITS-1:0] mem [DIM][DIM];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          mem[r][c] <= '0;
    end else if (we && int'(wrow) < DIM) begin
      for (int c = 0; c < DIM; c++)
        mem[wrow][c] <= wdata[c*BITS +: BITS];
    end
  for (genvar k = 0; k < DIM; k++) begin : g_rd
    assign rdata[k*BITS +: BITS] = mem[rrow[k*RB +: RB]][rcol[k*RB +: RB]];
  end
endmodule

// File: rtl/operand_skew_mem.sv
// operand_skew_mem: ping-pong operand tile memory streaming a diagonally skewed
// row-order (A) or column-order (B) feed into one edge of the systolic array
module operand_skew_mem import systolic_pkg::*; #(
  parameter int BITS_AB = 8,
  parameter int DIM = 8,
  parameter int TRANSPOSE = 0,
  localparam int RB = rowbits(DIM),
  localparam int SB = stepbits(DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WrEn,
  input  logic [RB-1:0]          Arow,
  input  logic [DIM*BITS_AB-1:0] Ain,
  input  logic                   swap,
  input  logic                   en,
  output logic [DIM*BITS_AB-1:0] Aout,
  output logic                   busy,
  output logic                   done
);
  localparam logic [SB-1:0] LAST = SB'(2 * DIM - 2);
  state_t state, state_n;
  logic [SB-1:0] s, s_n;
  logic lb, lb_n, done_n;
  logic [DIM*BITS_AB-1:0] aout_n, lane, rd0, rd1, rd;
  logic [DIM*RB-1:0] rrow, rcol;
  operand_bank #(.BITS(BITS_AB), .DIM(DIM)) u_bank0 (
    .clk(clk), .rst_n(rst_n), .we(WrEn & ~lb), .wrow(Arow), .wdata(Ain),
    .rrow(rrow), .rcol(rcol), .rdata(rd0)
  );
  operand_bank #(.BITS(BITS_AB), .DIM(DIM)) u_bank1 (
    .clk(clk), .rst_n(rst_n), .we(WrEn & lb), .wrow(Arow), .wdata(Ain),
    .rrow(rrow), .rcol(rcol), .rdata(rd1)
  );
  assign rd = lb ? rd0 : rd1;
  // lane i sits i steps behind lane 0; d is its position along the stored row/column
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [RB-1:0] d;
    logic v;
    assign d = RB'(s - SB'(i));
    assign v = int'(s) >= i && int'(s) < i + DIM;
    assign rrow[i*RB +: RB] = TRANSPOSE != 0 ? d : RB'(i);
    assign rcol[i*RB +: RB] = TRANSPOSE != 0 ? RB'(i) : d;
    assign lane[i*BITS_AB +: BITS_AB] = v ? rd[i*BITS_AB +: BITS_AB] : '0;
  end
  always_comb begin
    state_n = state;
    s_n = s;
    lb_n = lb;
    aout_n = Aout;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (swap) begin
        lb_n = ~lb;
        state_n = STREAM;
        s_n = '0;
      end else if (en) begin
        aout_n = '0;
      end
    end else if (en) begin
      aout_n = lane;
      state_n = s == LAST ? IDLE : STREAM;
      done_n = s == LAST;
      s_n = s == LAST ? '0 : s + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      s <= '0;
      lb <= 1'b0;
      Aout <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      s <= s_n;
      lb <= lb_n;
      Aout <= aout_n;
      done <= done_n;
    end
  assign busy = state == STREAM;
endmodule

// File: tb/tb_operand_skew_mem.sv
// tb_operand_skew_mem: A-feed and B-feed instances on shared stimulus, checked
// every cycle against a tile-level reference model plus hand-computed values
module tb_operand_skew_mem;
  import systolic_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic wr_en = 0;
  logic [2:0] arow = 0;
  logic [63:0] ain = 0;
  logic swap = 0;
  logic en = 0;
  logic [63:0] aout_a, aout_b;
  logic busy_a, busy_b, done_a, done_b;
  int checks = 0;
  int errors = 0;
  operand_t bank [2][8][8];
  operand_t ea [8];
  operand_t eb [8];
  int ms;
  bit mlb, mbusy, mdone;

  operand_skew_mem #(.BITS_AB(8), .DIM(8), .TRANSPOSE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .WrEn(wr_en), .Arow(arow), .Ain(ain),
    .swap(swap), .en(en), .Aout(aout_a), .busy(busy_a), .done(done_a)
  );
  operand_skew_mem #(.BITS_AB(8), .DIM(8), .TRANSPOSE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .WrEn(wr_en), .Arow(arow), .Ain(ain),
    .swap(swap), .en(en), .Aout(aout_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  function automatic int la(input int i);
    return int'($signed(aout_a[i*8 +: 8]));
  endfunction
  function automatic int lb_(input int i);
    return int'($signed(aout_b[i*8 +: 8]));
  endfunction

  // Reference: lane i of step s is T[i][s-i] (A) or T[s-i][i] (B), T being the bank not loading
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          bank[0][r][c] <= 0;
          bank[1][r][c] <= 0;
        end
      for (int i = 0; i < 8; i++) begin
        ea[i] <= 0;
        eb[i] <= 0;
      end
      ms <= 0;
      mlb <= 0;
      mbusy <= 0;
      mdone <= 0;
    end else begin
      if (wr_en)
        for (int c = 0; c < 8; c++) bank[mlb][arow][c] <= ain[c*8 +: 8];
      mdone <= 0;
      if (!mbusy) begin
        if (swap) begin
          mlb <= !mlb;
          mbusy <= 1;
          ms <= 0;
        end else if (en) begin
          for (int i = 0; i < 8; i++) begin
            ea[i] <= 0;
            eb[i] <= 0;
          end
        end
      end else if (en) begin
        for (int i = 0; i < 8; i++) begin
          ea[i] <= (ms - i >= 0 && ms - i < 8) ? bank[!mlb][i][(ms-i) & 7] : 0;
          eb[i] <= (ms - i >= 0 && ms - i < 8) ? bank[!mlb][(ms-i) & 7][i] : 0;
        end
        if (ms == 14) begin
          mbusy <= 0;
          mdone <= 1;
          ms <= 0;
        end else ms <= ms + 1;
      end
    end
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("model_a_lane%0d", i), la(i), int'(ea[i]));
      chk($sformatf("model_b_lane%0d", i), lb_(i), int'(eb[i]));
    end
    chk("model_busy_a", int'(busy_a), int'(mbusy));
    chk("model_busy_b", int'(busy_b), int'(mbusy));
    chk("model_done_a", int'(done_a), int'(mdone));
    chk("model_done_b", int'(done_b), int'(mdone));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_tile(input int kind);
    wr_en = 1;
    for (int r = 0; r < 8; r++) begin
      arow = 3'(r);
      for (int c = 0; c < 8; c++)
        ain[c*8 +: 8] = kind == 0 ? 8'(8 * r + c + 1) : 8'($urandom);
      tick();
    end
    wr_en = 0;
  endtask

  task automatic do_swap();
    swap = 1;
    tick();
    swap = 0;
  endtask

  task automatic drain();
    int n = 0;
    en = 1;
    while (busy_a && n < 20) begin
      tick();
      n++;
    end
    en = 0;
    chk("drain_timeout", int'(busy_a), 0);
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1;
    tick();
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_aout", int'(aout_a != 0 || aout_b != 0), 0);
    en = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("noswap_done", int'(done_a | done_b), 0);
    end
    chk("noswap_aout", int'(aout_a != 0 || aout_b != 0), 0);
    en = 0;
    chk("model_pin_idle", int'(mbusy), 0);

    load_tile(0);
    do_swap();
    chk("swap_busy", int'(busy_a & busy_b), 1);
    en = 1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 0) begin
        chk("s0_a_lane0", la(0), 1);
        chk("s0_a_lane1", la(1), 0);
        chk("s0_model_lane0", int'(ea[0]), 1);
      end
      if (k == 1) begin
        chk("s1_b_lane0", lb_(0), 9);
        chk("s1_b_lane1", lb_(1), 2);
      end
      if (k == 7) begin
        for (int i = 0; i < 8; i++) begin
          chk("s7_a_lane", la(i), 7 * i + 8);
          chk("s7_b_lane", lb_(i), 57 - 7 * i);
        end
        chk("s7_model_b_lane0", int'(eb[0]), 57);
      end
      if (k == 13) chk("s13_done", int'(done_a), 0);
      if (k == 14) begin
        chk("s14_a_lane7", la(7), 64);
        chk("s14_a_lane0", la(0), 0);
        chk("s14_done", int'(done_a & done_b), 1);
        chk("s14_busy", int'(busy_a), 0);
        chk("s14_model_done", int'(mdone), 1);
      end
    end
    en = 0;

    // ping-pong: tile B (all 5) is written while the random tile streams
    load_tile(1);
    do_swap();
    en = 1;
    for (int k = 0; k < 15; k++) begin
      wr_en = k < 8;
      arow = 3'(k);
      ain = {8{8'd5}};
      tick();
    end
    wr_en = 0;
    chk("pp_done", int'(done_a), 1);
    swap = 1;
    tick();
    swap = 0;
    chk("pp_restart_busy", int'(busy_a), 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 0) begin
        chk("pp_s0_lane0", la(0), 5);
        chk("pp_s0_lane1", lb_(1), 0);
      end
      if (k == 7)
        for (int i = 0; i < 8; i++) begin
          chk("pp_s7_a", la(i), 5);
          chk("pp_s7_b", lb_(i), 5);
        end
    end
    chk("pp_end_done", int'(done_b), 1);
    en = 0;

    // stall for three cycles at step 4 with an ignored swap and a load-bank write
    load_tile(1);
    do_swap();
    en = 1;
    for (int k = 0; k < 5; k++) tick();
    en = 0;
    for (int k = 0; k < 3; k++) begin
      swap = k == 1;
      wr_en = k == 1;
      arow = 3'($urandom_range(0, 7));
      ain = {$urandom, $urandom};
      tick();
    end
    swap = 0;
    wr_en = 0;
    chk("stall_busy", int'(busy_a), 1);
    en = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 8) chk("stall_s13_done", int'(done_a), 0);
      if (k == 9) chk("stall_s14_done", int'(done_a), 1);
    end
    en = 0;

    for (int n = 0; n < 400; n++) begin
      en = $urandom_range(0, 9) < 7;
      swap = $urandom_range(0, 9) == 0;
      wr_en = $urandom_range(0, 9) < 3;
      arow = 3'($urandom_range(0, 7));
      ain = {$urandom, $urandom};
      tick();
    end
    swap = 0;
    wr_en = 0;
    drain();

    load_tile(1);
    do_swap();
    en = 1;
    for (int k = 0; k < 7; k++) tick();
    rst_n = 0;
    #1;
    chk("rst_busy", int'(busy_a | busy_b), 0);
    chk("rst_done", int'(done_a | done_b), 0);
    chk("rst_aout", int'(aout_a != 0 || aout_b != 0), 0);
    en = 0;
    tick();
    rst_n = 1;
    tick();
    do_swap();
    en = 1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 7) chk("rst_zero_stream", int'(aout_a != 0 || aout_b != 0), 0);
    end
    chk("rst_stream_done", int'(done_a), 1);
    en = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_skew_mem.md
# operand_skew_mem

Double-buffered operand memory that feeds one edge of the systolic array. It holds a DIM×DIM signed tile per bank, loaded one row per cycle. It streams the tile out diagonally skewed, so lane i lags lane i-1 by one step, in either row order (A operand) or column/transpose order (B operand). Ping-pong banks let the next tile load while the current tile streams, replacing the single-bank, single-mode A/B memories.

## Interface
Parameters:
- BITS_AB, 8, signed operand width
- DIM, 8, tile dimension and lane count (≥2)
- TRANSPOSE, 0, 0 = lane i streams stored row i (A feed); 1 = lane j streams stored column j (B feed)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- WrEn  in  1  write Ain into row Arow of the load bank
- Arow  in  $clog2(DIM)  row address for WrEn
- Ain  in  DIM×BITS_AB signed  row data; element c → column c
- swap  in  1  exchange load/stream banks and arm a stream; ignored while busy
- en  in  1  advance stream one step (array enable)
- Aout  out  DIM×BITS_AB signed  skewed lane outputs, registered
- busy  out  1  stream armed or in progress
- done  out  1  one-cycle pulse on the edge emitting the final step

## Operation
- State: bank pointer lb (load bank; stream bank = ~lb), step counter s ∈ [0, 2·DIM-2], busy, done, Aout register.
- FSM: IDLE (busy=0) → swap → STREAM (busy=1, s=0) → final step emitted → IDLE.
- IDLE: swap toggles lb, sets busy, clears s. Edges with en and no stream: Aout <= 0, which supplies drain zeros.
- STREAM, edge with en=1: Aout[i] <= T[i][s-i] (TRANSPOSE=0) or T[s-i][i] (TRANSPOSE=1) when 0 ≤ s-i < DIM, else 0. T is the stream bank. s increments.
- STREAM, edge with en=0: Aout, s hold (stall).
- At s = 2·DIM-2 with en: emit, busy <= 0, done <= 1 (next cycle 0), s <= 0.
- Writes always target bank lb, whether IDLE or STREAM, and never disturb the stream bank.
- Boundary rules:
  - swap while busy: ignored, no state change.
  - swap and en in the same cycle (IDLE): swap applies; nothing is emitted; step 0 waits for the next en.
  - swap and WrEn in the same cycle: the write lands in the pre-swap lb. It is therefore part of the tile being streamed.
  - Arow ≥ DIM is impossible (DIM a power of two); for non-power-of-two DIM, the write is dropped.
  - Reset mid-stream: abort the stream, return to IDLE, clear all data.

## Timing
- Reset values: Aout all 0, busy 0, done 0, s 0, lb 0, both banks all 0.
- Aout latency: 1 cycle after the en edge; a stream is exactly 2·DIM-1 en-cycles.
- busy rises on the edge after swap; done coincides with the Aout update of the last step; busy falls on that same edge.
- A write is visible for streaming after the following swap; the earliest use is the edge after the write edge.
- Back-to-back tiles: swap may be asserted the cycle after done, giving a zero-gap restart.

## Structure
- Shared package systolic_pkg holds:
  - ROWBITS = $clog2(DIM) helper
  - typedef for a signed BITS_AB operand vector
  - step-width constant $clog2(2·DIM-1)
- Sub-module operand_bank: one DIM×DIM register bank with async-reset clear, row write port, and combinational element read by (row, col). Two instances; the skew/mux logic lives in operand_skew_mem.

## Test plan
- Reset, then 2·DIM en cycles with no swap → Aout all 0, busy 0, done never pulses.
- DIM=8, TRANSPOSE=0, load T[r][c]=8r+c+1, swap, 15× en:
  - step 0: lane0=1, others 0
  - step 7: lane i = 7i+8 (lane0=8, lane7=57)
  - step 14: lane7=64, others 0; done on this step only
- Same tile with TRANSPOSE=1:
  - step 7: lane j = 57-7j (lane0=57, lane7=8)
  - step 1: lane0=9, lane1=2
- Ping-pong: stream tile A, write tile B (all 5) during the stream, swap the cycle after done. A's outputs are unaffected; B streams 5s with the correct skew.
- Stall and ignored swap: drop en for 3 cycles at step 4 → Aout holds and s resumes at 5. swap mid-stream → no bank change, and the stream completes with the original data.
- Reset asserted at step 6 → Aout, busy, done 0 immediately. A following swap plus 15 en streams all zeros.
